mmc_sector_ring_buffer: RTL

//  Parametrised successor of the single-sector MMC buffer: a ring of P_BANK_N sector banks,

---
 rtl/mmc_buffer_pkg.sv | 26 ++
 rtl/mmc_sector_ring_buffer_if.sv | 41 ++++
 rtl/mmc_buffer_bank_ram.sv | 50 +++++
 rtl/mmc_sector_ring_buffer.sv | 119 +++++++++++
 4 files changed

// File: rtl/mmc_buffer_pkg.sv
// rtl/mmc_buffer_pkg.sv - shared bank-state encodings and byte-mask merge for the sector ring buffer
//
// Purpose: bank lifecycle encodings and the byte merge used by masked writes.
// Ports: none (package).
package mmc_buffer_pkg;

  localparam int L_BYTE_W = 8;

  // Bank lifecycle: FREE -> FILL -> FULL -> DRAIN -> FREE.
  typedef enum logic [1:0] {
    L_FREE  = 2'd0,
    L_FILL  = 2'd1,
    L_FULL  = 2'd2,
    L_DRAIN = 2'd3
  } bank_state_e;

  // A mask bit of 1 protects the byte; 0 lets the new byte through.
  function automatic logic [L_BYTE_W-1:0] merge_byte(
    input logic [L_BYTE_W-1:0] old_byte,
    input logic [L_BYTE_W-1:0] new_byte,
    input logic                protect
  );
    return protect ? old_byte : new_byte;
  endfunction

endpackage

// File: rtl/mmc_sector_ring_buffer_if.sv
// rtl/mmc_sector_ring_buffer_if.sv - write/read/commit/release bus of the sector ring buffer
//
// Purpose: groups the writer-side and reader-side handshake signals.
// Ports (master drives the i* signals, slave drives the o* signals):
//   iWR_REQ/iWR_MASK/iWR_ADDR/iWR_DATA/iWR_COMMIT, oWR_BUSY   writer side
//   iRD_REQ/iRD_ADDR/iRD_RELEASE, oRD_VALID/oRD_DATA/oRD_READY reader side
//   oLEVEL                                                     banks FULL or DRAIN
interface mmc_sector_ring_buffer_if #(
  parameter int P_DATA_N = 32,
  parameter int P_ADDR_N = 7,
  parameter int P_BANK_N = 2
);
  localparam int L_LVL_W = $clog2(P_BANK_N + 1);

  logic                  iWR_REQ;
  logic [P_DATA_N/8-1:0] iWR_MASK;
  logic [P_ADDR_N-1:0]   iWR_ADDR;
  logic [P_DATA_N-1:0]   iWR_DATA;
  logic                  iWR_COMMIT;
  logic                  oWR_BUSY;
  logic                  iRD_REQ;
  logic [P_ADDR_N-1:0]   iRD_ADDR;
  logic                  oRD_VALID;
  logic [P_DATA_N-1:0]   oRD_DATA;
  logic                  iRD_RELEASE;
  logic                  oRD_READY;
  logic [L_LVL_W-1:0]    oLEVEL;

  modport master (
    output iWR_REQ, iWR_MASK, iWR_ADDR, iWR_DATA, iWR_COMMIT,
    output iRD_REQ, iRD_ADDR, iRD_RELEASE,
    input  oWR_BUSY, oRD_VALID, oRD_DATA, oRD_READY, oLEVEL
  );

  modport slave (
    input  iWR_REQ, iWR_MASK, iWR_ADDR, iWR_DATA, iWR_COMMIT,
    input  iRD_REQ, iRD_ADDR, iRD_RELEASE,
    output oWR_BUSY, oRD_VALID, oRD_DATA, oRD_READY, oLEVEL
  );

endinterface

// File: rtl/mmc_buffer_bank_ram.sv
// rtl/mmc_buffer_bank_ram.sv - flat byte-maskable RAM holding all sector banks
//
// Purpose: one RAM of 2**P_DEPTH_W words; the bank index is the upper address bits.
// Ports:
//   iCLOCK, inRESET      clock, async active-low reset (read register only)
//   iWR_EN/iWR_MASK/iWR_ADDR/iWR_DATA   byte-masked write port (mask 1 = protect)
//   iRD_EN/iRD_ADDR, oRD_DATA            registered read port, holds when idle
import mmc_buffer_pkg::*;

module mmc_buffer_bank_ram #(
  parameter int P_DATA_N  = 32,
  parameter int P_DEPTH_W = 8
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  input  logic                  iWR_EN,
  input  logic [P_DATA_N/8-1:0] iWR_MASK,
  input  logic [P_DEPTH_W-1:0]  iWR_ADDR,
  input  logic [P_DATA_N-1:0]   iWR_DATA,
  input  logic                  iRD_EN,
  input  logic [P_DEPTH_W-1:0]  iRD_ADDR,
  output logic [P_DATA_N-1:0]   oRD_DATA
);
  localparam int L_BYTES = P_DATA_N / L_BYTE_W;

  logic [P_DATA_N-1:0] mem [2**P_DEPTH_W];
  logic [P_DATA_N-1:0] rd_data_q;

  // Storage survives reset, so the array has no reset branch.
  always_ff @(posedge iCLOCK) begin
    if (iWR_EN) begin
      for (int b = 0; b < L_BYTES; b++) begin
        mem[iWR_ADDR][b*L_BYTE_W +: L_BYTE_W] <=
          merge_byte(mem[iWR_ADDR][b*L_BYTE_W +: L_BYTE_W],
                     iWR_DATA[b*L_BYTE_W +: L_BYTE_W], iWR_MASK[b]);
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rd_data_q <= '0;
    end else if (iRD_EN) begin
      rd_data_q <= mem[iRD_ADDR];
    end
  end

  assign oRD_DATA = rd_data_q;

endmodule

// File: rtl/mmc_sector_ring_buffer.sv
// rtl/mmc_sector_ring_buffer.sv - ring of byte-maskable sector banks between MMC engine and DMA
//
// Purpose: writer fills and commits banks in ring order; reader drains committed banks
//          in the same order and releases them. Read data is registered (latency 1).
// Ports:
//   iCLOCK   clock, all logic on posedge
//   inRESET  asynchronous active-low reset
//   bus      mmc_sector_ring_buffer_if.slave (write, commit, read, release, status)
import mmc_buffer_pkg::*;

module mmc_sector_ring_buffer #(
  parameter int P_DATA_N = 32,
  parameter int P_ADDR_N = 7,
  parameter int P_BANK_N = 2
) (
  input  logic                          iCLOCK,
  input  logic                          inRESET,
  mmc_sector_ring_buffer_if.slave       bus
);
  localparam int L_PTR_W = $clog2(P_BANK_N);
  localparam int L_LVL_W = $clog2(P_BANK_N + 1);

  bank_state_e          state_q [P_BANK_N];
  bank_state_e          state_d [P_BANK_N];
  logic [L_PTR_W-1:0]   wr_ptr_q;
  logic [L_PTR_W-1:0]   rd_ptr_q;
  logic [L_LVL_W-1:0]   level_q;
  logic                 rd_valid_q;

  logic wr_open;
  logic rd_ready;
  logic wr_acc;
  logic commit_acc;
  logic rd_acc;
  logic rel_acc;

  // The write bank is open until committed; the read bank is ready once committed.
  assign wr_open    = (state_q[wr_ptr_q] == L_FREE) || (state_q[wr_ptr_q] == L_FILL);
  assign rd_ready   = (state_q[rd_ptr_q] == L_FULL) || (state_q[rd_ptr_q] == L_DRAIN);
  assign wr_acc     = bus.iWR_REQ && wr_open;
  assign commit_acc = bus.iWR_COMMIT && wr_open;
  assign rd_acc     = bus.iRD_REQ && rd_ready;
  assign rel_acc    = bus.iRD_RELEASE && rd_ready;

  // An accepted commit targets an open bank and an accepted release a committed one,
  // so the two never collide on the same bank. Commit overrides FREE->FILL, which is
  // how a same-cycle write lands before the bank is closed.
  always_comb begin
    for (int i = 0; i < P_BANK_N; i++) begin
      state_d[i] = state_q[i];
    end
    if (wr_acc && (state_q[wr_ptr_q] == L_FREE)) begin
      state_d[wr_ptr_q] = L_FILL;
    end
    if (commit_acc) begin
      state_d[wr_ptr_q] = L_FULL;
    end
    if (rd_acc && (state_q[rd_ptr_q] == L_FULL)) begin
      state_d[rd_ptr_q] = L_DRAIN;
    end
    if (rel_acc) begin
      state_d[rd_ptr_q] = L_FREE;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < P_BANK_N; i++) begin
        state_q[i] <= L_FREE;
      end
    end else begin
      for (int i = 0; i < P_BANK_N; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Pointers wrap naturally because the bank count is a power of two.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (commit_acc) begin
        wr_ptr_q <= wr_ptr_q + L_PTR_W'(1);
      end
      if (rel_acc) begin
        rd_ptr_q <= rd_ptr_q + L_PTR_W'(1);
      end
      level_q    <= level_q + L_LVL_W'(commit_acc) - L_LVL_W'(rel_acc);
      rd_valid_q <= rd_acc;
    end
  end

  // Read address uses the pre-release rd_ptr, so a read issued with release
  // still returns data from the bank being released.
  mmc_buffer_bank_ram #(
    .P_DATA_N  (P_DATA_N),
    .P_DEPTH_W (L_PTR_W + P_ADDR_N)
  ) u_ram (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .iWR_EN   (wr_acc),
    .iWR_MASK (bus.iWR_MASK),
    .iWR_ADDR ({wr_ptr_q, bus.iWR_ADDR}),
    .iWR_DATA (bus.iWR_DATA),
    .iRD_EN   (rd_acc),
    .iRD_ADDR ({rd_ptr_q, bus.iRD_ADDR}),
    .oRD_DATA (bus.oRD_DATA)
  );

  assign bus.oWR_BUSY  = !wr_open;
  assign bus.oRD_READY = rd_ready;
  assign bus.oRD_VALID = rd_valid_q;
  assign bus.oLEVEL    = level_q;

endmodule
